// File: rtl/fpadd_share_arbiter_if.sv
// Requester, response and datapath signals of the shared FP adder arbiter.
// slave is the arbiter side; master is the requesters plus datapath side.
interface fpadd_share_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               dp_issue;
  logic [31:0]        dp_a;
  logic [31:0]        dp_b;
  logic               dp_res_valid;
  logic [31:0]        dp_res;
  logic [NREQ-1:0]    rsp_valid;
  logic [NREQ*32-1:0] rsp_data;
  logic [NREQ-1:0]    rsp_ready;
  logic [3:0]         inflight;
  logic               err_orphan;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    input  dp_res_valid, dp_res,
    output req_ready, dp_issue, dp_a, dp_b,
    output rsp_valid, rsp_data, inflight, err_orphan
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    output dp_res_valid, dp_res,
    input  req_ready, dp_issue, dp_a, dp_b,
    input  rsp_valid, rsp_data, inflight, err_orphan
  );
endinterface

// File: rtl/fpadd_share_arbiter.sv
// Round-robin sharing of one fixed-latency FP adder between requesters,
// with an ID tag pipe steering each sum back to its response register.
module fpadd_share_arbiter #(
  parameter int NREQ = 4,
  parameter int LAT  = 4,
  parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fpadd_share_arbiter_if.slave bus
);

  logic [NREQ-1:0]    busy;
  logic [NREQ-1:0]    elig;
  logic [NREQ-1:0]    rsp_v;
  logic [NREQ*32-1:0] rsp_d;
  logic [IDW-1:0]     rr;
  logic [IDW-1:0]     gnt;
  logic               found;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [LAT-1:0]     tv;
  logic [IDW-1:0]     tid [LAT];
  logic [3:0]         infl;
  logic               err;
  logic               ret;
  logic [IDW-1:0]     rid;

  // Grant is suppressed while reset is held so no handshake leaks out.
  assign elig = bus.req_valid & ~busy & {NREQ{rst_n}};

  always_comb begin
    found = 1'b0;
    gnt   = '0;
    for (int o = 0; o < NREQ; o++) begin
      if (!found && elig[(int'(rr) + o) % NREQ]) begin
        found = 1'b1;
        gnt   = IDW'((int'(rr) + o) % NREQ);
      end
    end
  end

  assign ret = tv[LAT-1];
  assign rid = tid[LAT-1];

  assign bus.req_ready  = found ? (NREQ'(1) << gnt) : '0;
  assign bus.dp_issue   = found;
  assign bus.dp_a       = found ? bus.req_a[int'(gnt)*32 +: 32] : a_q;
  assign bus.dp_b       = found ? bus.req_b[int'(gnt)*32 +: 32] : b_q;
  assign bus.rsp_valid  = rsp_v;
  assign bus.rsp_data   = rsp_d;
  assign bus.inflight   = infl;
  assign bus.err_orphan = err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy  <= '0;
      rsp_v <= '0;
      rsp_d <= '0;
      rr    <= '0;
      a_q   <= '0;
      b_q   <= '0;
      tv    <= '0;
      infl  <= '0;
      err   <= 1'b0;
      for (int i = 0; i < LAT; i++) tid[i] <= '0;
    end else begin
      if (found) begin
        a_q <= bus.req_a[int'(gnt)*32 +: 32];
        b_q <= bus.req_b[int'(gnt)*32 +: 32];
        rr  <= (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
      end
      tv[0]  <= found;
      tid[0] <= gnt;
      for (int i = 1; i < LAT; i++) begin
        tv[i]  <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      infl <= infl + {3'b0, found} - {3'b0, ret};
      for (int k = 0; k < NREQ; k++) begin
        if (rsp_v[k] && bus.rsp_ready[k]) begin
          rsp_v[k] <= 1'b0;
          busy[k]  <= 1'b0;
        end
      end
      if (ret && bus.dp_res_valid) begin
        rsp_v[rid]                <= 1'b1;
        rsp_d[int'(rid)*32 +: 32] <= bus.dp_res;
      end else if (ret) begin
        busy[rid] <= 1'b0;
        err       <= 1'b1;
      end else if (bus.dp_res_valid) begin
        err <= 1'b1;
      end
      if (found) busy[gnt] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fpadd_share_arbiter.sv
// Directed bench for fpadd_share_arbiter with a fixed-latency datapath model
// whose sums come from a hand-computed operand table.
module tb_fpadd_share_arbiter;

  localparam int NREQ = 4;
  localparam int LAT  = 4;

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  logic clk;
  logic rst_n;

  fpadd_share_arbiter_if #(.NREQ(NREQ)) bus ();

  fpadd_share_arbiter #(
    .NREQ(NREQ),
    .LAT (LAT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  vec_t        vt [5];
  int          n_pass;
  int          n_total;
  logic        inject;
  logic [31:0] inj_val;
  logic        suppress;
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  logic [3:0]     exp_g [12];
  int          bad;
  int          others;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++)
      if (vt[i].a == a && vt[i].b == b) r = vt[i].sum;
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= bus.dp_issue;
      pd[0] <= fadd(bus.dp_a, bus.dp_b);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end

  assign bus.dp_res_valid = (pv[LAT-1] & ~suppress) | inject;
  assign bus.dp_res       = inject ? inj_val : pd[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*32 +: 32] = a;
    bus.req_b[i*32 +: 32] = b;
  endtask

  task automatic drain(input int n);
    bus.req_valid = '0;
    bus.rsp_ready = '1;
    repeat (n) cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_pass   = 0;
    n_total  = 0;
    inject   = 1'b0;
    inj_val  = '0;
    suppress = 1'b0;
    rst_n    = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;

    vt[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40400000};
    vt[1] = '{2, 32'h3F000000, 32'h3E800000, 32'h3F400000};
    vt[2] = '{1, 32'h41200000, 32'hC0A00000, 32'h40A00000};
    vt[3] = '{0, 32'h40400000, 32'h3F800000, 32'h40800000};
    vt[4] = '{3, 32'h40000000, 32'h40000000, 32'h40800000};
    exp_g = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0,
              4'h1, 4'h2, 4'h4, 4'h8, 4'h0, 4'h0};

    repeat (2) cyc();
    #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_dp_issue", 32'(bus.dp_issue), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_inflight", 32'(bus.inflight), 0);
    chk("rst_err", 32'(bus.err_orphan), 0);
    chk("rst_dp_a", bus.dp_a, 0);
    chk("rst_rsp_data0", bus.rsp_data[31:0], 0);
    cyc();
    rst_n = 1'b1;

    // single operations, one per table row
    for (int v = 0; v < 5; v++) begin
      cyc();
      set_ops(vt[v].id, vt[v].a, vt[v].b);
      bus.req_valid = 4'(1 << vt[v].id);
      #1;
      chk("sg_grant", 32'(bus.req_ready), 32'(1 << vt[v].id));
      chk("sg_issue", 32'(bus.dp_issue), 1);
      chk("sg_dp_a", bus.dp_a, vt[v].a);
      chk("sg_dp_b", bus.dp_b, vt[v].b);
      for (int c = 1; c <= LAT; c++) begin
        cyc();
        bus.req_valid = '0;
        #1;
        chk("sg_inflight", 32'(bus.inflight), 1);
        chk("sg_rsp_early", 32'(bus.rsp_valid), 0);
      end
      cyc();
      bus.rsp_ready = 4'(1 << vt[v].id);
      #1;
      chk("sg_rsp_valid", 32'(bus.rsp_valid), 32'(1 << vt[v].id));
      chk("sg_rsp_data", bus.rsp_data[vt[v].id*32 +: 32], vt[v].sum);
      chk("sg_inflight0", 32'(bus.inflight), 0);
      cyc();
      bus.rsp_ready = '0;
      #1;
      chk("sg_consumed", 32'(bus.rsp_valid), 0);
      chk("sg_data_held", bus.rsp_data[vt[v].id*32 +: 32], vt[v].sum);
    end

    // round robin with all requesters valid
    for (int i = 0; i < NREQ; i++) set_ops(i, vt[i].a, vt[i].b);
    for (int c = 0; c < 12; c++) begin
      cyc();
      bus.req_valid = '1;
      bus.rsp_ready = '1;
      #1;
      chk($sformatf("rr_grant_c%0d", c), 32'(bus.req_ready), 32'(exp_g[c]));
      if (c == 5) chk("rr_rsp0", bus.rsp_data[31:0], vt[0].sum);
    end
    cyc();
    drain(8);
    #1;
    chk("rr_drained_inflight", 32'(bus.inflight), 0);
    chk("rr_drained_rsp", 32'(bus.rsp_valid), 0);

    // requester 2 withholds rsp_ready
    bad    = 0;
    others = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      bus.req_valid = '1;
      bus.rsp_ready = 4'b1011;
      #1;
      if (c >= 8) begin
        if (bus.rsp_valid[2] !== 1'b1) bad++;
        if (bus.rsp_data[64 +: 32] !== vt[2].sum) bad++;
        if (bus.req_ready[2] !== 1'b0) bad++;
        if (bus.req_ready != '0) others++;
      end
    end
    chk("bp_stable", 32'(bad), 0);
    chk("bp_others_served", 32'(others >= 4), 1);
    cyc();
    drain(8);
    #1;
    chk("bp_released", 32'(bus.rsp_valid), 0);
    chk("bp_inflight", 32'(bus.inflight), 0);

    // pointer wrap: grant 2 leaves rr=3, then lone requester 1
    cyc();
    bus.req_valid = 4'b0100;
    #1;
    chk("wr_g2", 32'(bus.req_ready), 32'h4);
    cyc();
    drain(7);
    bus.req_valid = 4'b0010;
    #1;
    chk("wr_g1", 32'(bus.req_ready), 32'h2);
    cyc();
    drain(7);
    bus.req_valid = 4'b1101;
    #1;
    chk("wr_next2", 32'(bus.req_ready), 32'h4);
    cyc();
    #1;
    chk("wr_next3", 32'(bus.req_ready), 32'h8);
    cyc();
    #1;
    chk("wr_next0", 32'(bus.req_ready), 32'h1);
    cyc();
    drain(8);

    // orphan result with empty tag pipe
    inj_val = 32'h12345678;
    inject  = 1'b1;
    #1;
    chk("or_before", 32'(bus.err_orphan), 0);
    cyc();
    inject = 1'b0;
    #1;
    chk("or_set", 32'(bus.err_orphan), 1);
    chk("or_no_rsp", 32'(bus.rsp_valid), 0);
    chk("or_inflight", 32'(bus.inflight), 0);
    repeat (3) cyc();
    #1;
    chk("or_sticky", 32'(bus.err_orphan), 1);

    // reset while three ops are in flight
    cyc();
    bus.req_valid = 4'b0111;
    repeat (3) cyc();
    #1;
    chk("rm_inflight3", 32'(bus.inflight), 3);
    rst_n = 1'b0;
    #1;
    chk("rm_req_ready", 32'(bus.req_ready), 0);
    chk("rm_issue", 32'(bus.dp_issue), 0);
    chk("rm_inflight", 32'(bus.inflight), 0);
    chk("rm_err", 32'(bus.err_orphan), 0);
    chk("rm_dp_a", bus.dp_a, 0);
    chk("rm_rsp_data", bus.rsp_data[31:0], 0);
    cyc();
    rst_n = 1'b1;
    bus.req_valid = '0;
    cyc();
    bus.req_valid = 4'b1000;
    #1;
    chk("rm_new_grant", 32'(bus.req_ready), 32'h8);
    for (int c = 1; c <= LAT; c++) begin
      cyc();
      bus.req_valid = '0;
      bus.rsp_ready = '0;
    end
    cyc();
    #1;
    chk("rm_new_rsp", 32'(bus.rsp_valid), 32'h8);
    chk("rm_new_data", bus.rsp_data[96 +: 32], vt[3].sum);
    chk("rm_no_orphan", 32'(bus.err_orphan), 0);
    drain(3);

    // tag arrives with no datapath result
    bus.rsp_ready = '0;
    bus.req_valid = 4'b0001;
    #1;
    chk("dt_grant", 32'(bus.req_ready), 32'h1);
    for (int c = 1; c <= LAT; c++) begin
      cyc();
      bus.req_valid = '0;
      suppress      = 1'b1;
    end
    cyc();
    suppress      = 1'b0;
    bus.req_valid = 4'b0001;
    #1;
    chk("dt_no_rsp", 32'(bus.rsp_valid), 0);
    chk("dt_err", 32'(bus.err_orphan), 1);
    chk("dt_inflight", 32'(bus.inflight), 0);
    chk("dt_regrant", 32'(bus.req_ready), 32'h1);
    cyc();
    drain(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fpadd_share_arbiter.md
Name: fpadd_share_arbiter

Overview:
- Shares one pipelined FP adder datapath (unpack/align/add/normalize/pack, fixed latency) between NREQ requesters.
- Picks one request per cycle by round-robin and issues its operands to the datapath.
- Carries each requester's ID alongside the operation through a tag pipeline of matching latency.
- Routes each returning sum into that requester's response register, which is held until consumed.

Parameters:
- NREQ, 4, number of requesters (2..8)
- LAT, 4, datapath latency in cycles from dp_issue to dp_res_valid (1..8)
- IDW, 2, tag width; equals clog2(NREQ), minimum 1

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester request valid
- req_a  in  NREQ*32  operand A, IEEE-754 single; requester i occupies bits [32i+31:32i]
- req_b  in  NREQ*32  operand B, same packing as req_a
- req_ready  out  NREQ  request accepted this cycle (one-hot or zero)
- dp_issue  out  1  operands presented to datapath this cycle
- dp_a  out  32  operand A to datapath
- dp_b  out  32  operand B to datapath
- dp_res_valid  in  1  datapath result valid; asserted exactly LAT cycles after each dp_issue
- dp_res  in  32  datapath sum
- rsp_valid  out  NREQ  response valid per requester
- rsp_data  out  NREQ*32  per-requester result register, same packing as req_a
- rsp_ready  in  NREQ  requester consumes response
- inflight  out  4  number of operations issued but not yet returned (0..LAT)
- err_orphan  out  1  sticky: dp_res_valid arrived with no matching tag

Behaviour:
- Reset (async assert, sync deassert):
  - req_ready, dp_issue, rsp_valid, inflight and err_orphan = 0.
  - rsp_data and dp_a/dp_b = 0.
  - Round-robin pointer = 0; busy[] = 0; tag pipeline cleared.
- Eligibility: requester i is eligible when req_valid[i] & !busy[i]. busy[i] is set on grant and cleared when its response is consumed, so each requester has at most one operation outstanding.
- Arbitration (combinational from registered state):
  - Search starts at pointer rr and wraps modulo NREQ.
  - The first eligible requester g gets req_ready[g]=1.
  - In the same cycle: dp_issue=1, dp_a/dp_b = req_a/req_b slice g.
  - At the clock edge: busy[g] set; rr <= (g+1) mod NREQ. rr holds when there is no grant.
- No eligible requester: dp_issue=0, dp_a/dp_b hold their last values.
- Tag pipeline: LAT stages of {valid, id}. Stage 0 loads {dp_issue, g} and the pipeline shifts every cycle with no stall. The datapath has no backpressure.
- Return:
  - When dp_res_valid=1 and the last tag stage is valid with id k: rsp_data[k] <= dp_res and rsp_valid[k] <= 1.
  - When dp_res_valid=1 and the last tag stage is invalid: result dropped, err_orphan <= 1 (sticky until reset).
  - When the last tag stage is valid but dp_res_valid=0: tag dropped, err_orphan <= 1, busy[k] cleared.
- Response handshake:
  - rsp_valid[k] & rsp_ready[k] at an edge clears rsp_valid[k] and busy[k].
  - rsp_data[k] holds its value after consumption.
- inflight counts issues minus returns per cycle. A simultaneous issue and return leaves it unchanged. With single outstanding per requester, inflight ≤ min(LAT, NREQ).
- Simultaneous events:
  - Requester k cannot be re-granted in the cycle its response is consumed. busy clears at that edge, so the earliest re-grant is the next cycle.
  - A return and a consume for different requesters in the same cycle are independent.
- Async reset mid-operation discards all in-flight tags. Any late datapath results after reset release raise err_orphan. Integration resets the datapath with the same rst_n.
- Throughput: one issue per cycle maximum. A single requester achieves one op per LAT+2 cycles (grant, LAT, consume).

Test Plan:
- Single op: req_valid=0001, a=0x3F800000, b=0x40000000; model datapath returns 0x40400000 at LAT=4 → dp_issue in cycle 0; rsp_valid[0]=1 in cycle 5, rsp_data[0]=0x40400000; inflight 1 during cycles 1-4, then 0.
- Round-robin fairness: all 4 requesters valid continuously with rsp_ready=1111 → grants in order 0,1,2,3 in consecutive cycles; the next round starts at 0 only after busy[0] clears; no requester granted twice before the others.
- Backpressure: requester 2 holds rsp_ready[2]=0 for 10 cycles → rsp_valid[2] and rsp_data[2] stable throughout; req_ready[2]=0 throughout; other requesters keep being served.
- Wrap pointer: rr=3, only requester 1 valid → grant 1, rr becomes 2.
- Orphan: inject dp_res_valid=1 with an empty tag pipeline → err_orphan=1 next cycle and stays set; no rsp_valid change.
- Reset mid-flight: assert rst_n=0 with inflight=3 → all outputs 0 immediately; after release, a new request completes normally in LAT+1 cycles.
